// File: rtl/run_pattern_tx_pkg.sv
// Shared definitions for the run-length pattern transmitter.
package run_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    // Equal-bit streak length at which the detector must assert z.
    localparam int unsigned DETECT_LEN_DEF = 4;

    // Bits needed to hold a streak count of 0..len.
    function automatic int unsigned streak_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/run_pattern_tx_token_fifo.sv
// Token FIFO: synchronous, registered occupancy count, full/empty flags.
// Read data is the current head; a pop advances past it at the clock edge.
module token_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/run_pattern_tx.sv
// Serial run-length pattern transmitter feeding a four-in-a-row detector.
// Tokens (bit, length) are buffered and expanded into one serial bit per
// tick; z_expect tracks what a correct detector must output for the stream.
module run_pattern_tx
    import run_pattern_tx_pkg::*;
#(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DETECT_LEN = DETECT_LEN_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             tick,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [CNT_W-1:0] in_len,
    output logic             w_out,
    output logic             w_valid,
    output logic             z_expect,
    output logic             run_done,
    output logic             busy
);

    localparam int unsigned SW  = streak_width(DETECT_LEN);
    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam logic [SW-1:0] DET_MAX = SW'(DETECT_LEN);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    state_t           state;
    state_t           state_n;

    logic             cur_bit;
    logic [CNT_W-1:0] remain;
    logic [SW-1:0]    streak;
    logic [SW-1:0]    streak_n;

    logic             push;
    logic             pop;
    logic             emit;
    logic             last_bit;
    logic [CNT_W:0]   head;
    logic             head_bit;
    logic [CNT_W-1:0] head_len;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    assign push     = in_valid && !fifo_full;
    assign in_ready = !fifo_full;
    assign head_bit = head[CNT_W];
    assign head_len = head[CNT_W-1:0];
    assign last_bit = (remain == CNT_W'(1));
    assign busy     = (state != ST_IDLE) || !fifo_empty;

    token_fifo #(
        .WIDTH (CNT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push),
        .wdata ({in_bit, in_len}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state decode: pop in FETCH, emit in SEND on tick.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        emit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_n = ST_FETCH;
            end
            ST_FETCH: begin
                if (fifo_empty) begin
                    state_n = ST_IDLE;
                end else begin
                    pop = 1'b1;
                    if (head_len != '0) begin
                        state_n = ST_SEND;
                    end else if (fifo_count == ONE_CNT && !push) begin
                        // The discarded token was the last one buffered.
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_FETCH;
                    end
                end
            end
            ST_SEND: begin
                if (tick) begin
                    emit = 1'b1;
                    if (last_bit) state_n = fifo_empty ? ST_IDLE : ST_FETCH;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Streak of equal emitted bits, saturating at the detect length.
    always_comb begin
        streak_n = streak;
        if (streak == '0 || cur_bit != w_out) begin
            streak_n = SW'(1);
        end else if (streak < DET_MAX) begin
            streak_n = streak + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Run counter, serial output and detector-expectation registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cur_bit  <= 1'b0;
            remain   <= '0;
            streak   <= '0;
            w_out    <= 1'b0;
            w_valid  <= 1'b0;
            z_expect <= 1'b0;
            run_done <= 1'b0;
        end else begin
            w_valid  <= emit;
            run_done <= emit && last_bit;
            if (pop) begin
                cur_bit <= head_bit;
                remain  <= head_len;
            end
            if (emit) begin
                w_out    <= cur_bit;
                if (remain != '0) remain <= remain - 1'b1;
                streak   <= streak_n;
                z_expect <= (streak_n >= DET_MAX);
            end
        end
    end

endmodule

// File: tb/tb_run_pattern_tx.sv
// Self-checking bench for run_pattern_tx with a token-level reference model.
module tb_run_pattern_tx;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DETLEN = 4;

    typedef struct packed {
        logic b;
        logic z;
        logic rd;
    } ev_t;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             tick = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_bit = 1'b0;
    logic [CNT_W-1:0] in_len = '0;
    logic             w_out;
    logic             w_valid;
    logic             z_expect;
    logic             run_done;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int stray  = 0;
    int tick_mode = 0;   // 0 off, 1 always, 2 random, 3 manual

    ev_t exp_q[$];
    ev_t obs_q[$];

    // Reference model state: last emitted bit and unsaturated run of equal bits.
    logic m_prev;
    bit   m_have;
    int   m_streak;

    run_pattern_tx #(
        .CNT_W      (CNT_W),
        .DEPTH      (DEPTH),
        .DETECT_LEN (DETLEN)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .tick     (tick),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bit   (in_bit),
        .in_len   (in_len),
        .w_out    (w_out),
        .w_valid  (w_valid),
        .z_expect (z_expect),
        .run_done (run_done),
        .busy     (busy)
    );

    always #5 Clock = ~Clock;

    // Tick generator.
    always @(posedge Clock) begin
        #1;
        case (tick_mode)
            0: tick = 1'b0;
            1: tick = 1'b1;
            2: tick = ($urandom_range(0, 3) != 0);
            default: ;
        endcase
    end

    // Capture every emitted bit.
    always @(negedge Clock) begin
        if (!Reset) begin
            if (w_valid) obs_q.push_back('{b: w_out, z: z_expect, rd: run_done});
            else if (run_done) stray++;
        end
    end

    function automatic void model_reset();
        exp_q.delete();
        obs_q.delete();
        m_have = 0;
        m_prev = 1'b0;
        m_streak = 0;
    endfunction

    function automatic void model_push(input logic b, input int len);
        for (int i = 0; i < len; i++) begin
            if (m_have && b == m_prev) m_streak++;
            else m_streak = 1;
            m_prev = b;
            m_have = 1;
            exp_q.push_back('{b: b, z: (m_streak >= DETLEN), rd: (i == len - 1)});
        end
    endfunction

    task automatic do_reset();
        @(posedge Clock); #1;
        Reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic push_token(input logic b, input int len);
        bit done = 0;
        @(posedge Clock); #1;
        in_valid = 1'b1;
        in_bit = b;
        in_len = CNT_W'(len);
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge Clock);
            if (in_ready) begin
                @(posedge Clock); #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (done) model_push(b, len);
        else begin
            errors++;
            $display("FAIL push_accept: token (%0d,%0d) not accepted, required acceptance", b, len);
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge Clock);
            if (!busy && obs_q.size() >= exp_q.size()) ok = 1;
        end
        repeat (2) @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checks += 6;
        if (w_out !== 1'b0)    begin errors++; $display("FAIL reset_w_out: got %b want 0", w_out); end
        if (w_valid !== 1'b0)  begin errors++; $display("FAIL reset_w_valid: got %b want 0", w_valid); end
        if (z_expect !== 1'b0) begin errors++; $display("FAIL reset_z: got %b want 0", z_expect); end
        if (run_done !== 1'b0) begin errors++; $display("FAIL reset_run_done: got %b want 0", run_done); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        #1 Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_run();
        bit ok;
        do_reset();
        tick_mode = 1;
        push_token(1'b1, 5);
        wait_drain(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL single_drain: timeout, required drain"); end
        if (obs_q.size() !== 5) begin errors++; $display("FAIL single_count: got %0d want 5", obs_q.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_bit%0d: got b/z/rd=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_two_tokens();
        bit ok;
        int rd_cnt = 0;
        tick_mode = 1;
        push_token(1'b0, 2);
        push_token(1'b0, 3);
        wait_drain(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL two_drain: timeout, required drain"); end
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL two_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (obs_q[i]) rd_cnt += int'(obs_q[i].rd);
        if (rd_cnt !== 2) begin errors++; $display("FAIL two_run_done: got %0d want 2", rd_cnt); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL two_bit%0d: got b/z/rd=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_zero_len();
        bit ok;
        tick_mode = 1;
        push_token(1'b1, 0);
        push_token(1'b0, 1);
        wait_drain(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL zero_drain: timeout, required drain"); end
        if (obs_q.size() !== 1) begin errors++; $display("FAIL zero_count: got %0d want 1", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL zero_bit%0d: got b/z/rd=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_fill();
        bit ok;
        bit freed = 0;
        int accepted = 0;
        logic b;
        tick_mode = 3;
        tick = 1'b0;
        @(posedge Clock); #1;
        b = 1'(($urandom));
        in_valid = 1'b1; in_bit = b; in_len = CNT_W'(3);
        for (int c = 0; c < 20; c++) begin
            bit take;
            @(negedge Clock);
            take = in_ready;
            @(posedge Clock); #1;
            if (take) begin
                model_push(b, 3);
                accepted++;
                b = 1'(($urandom));
                in_bit = b;
            end
        end
        in_valid = 1'b0;
        @(negedge Clock);
        checks += 2;
        if (accepted !== DEPTH + 1) begin errors++; $display("FAIL fill_accepted: got %0d want %0d", accepted, DEPTH + 1); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", in_ready); end
        @(posedge Clock); #1 tick = 1'b1;
        @(posedge Clock); #1 tick = 1'b0;
        repeat (3) @(negedge Clock);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_one_tick: in_ready got %b want 0", in_ready); end
        @(posedge Clock); #1 tick = 1'b1;
        repeat (2) @(posedge Clock);
        #1 tick = 1'b0;
        for (int c = 0; c < 6 && !freed; c++) begin
            @(negedge Clock);
            if (in_ready) freed = 1;
        end
        checks++;
        if (!freed) begin errors++; $display("FAIL fill_freed: in_ready got 0 want 1 after run end"); end
        tick_mode = 1;
        wait_drain(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL fill_drain: timeout, required drain"); end
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL fill_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL fill_bit%0d: got b/z/rd=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_pattern();
        bit ok;
        do_reset();
        tick_mode = 1;
        push_token(1'b1, 3);
        push_token(1'b0, 4);
        push_token(1'b1, 2);
        wait_drain(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL pattern_drain: timeout, required drain"); end
        if (obs_q.size() !== 9) begin errors++; $display("FAIL pattern_count: got %0d want 9", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks += 2;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL pattern_bit%0d: got b/z/rd=%b want %b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i].z !== (i == 6)) begin
                errors++;
                $display("FAIL pattern_z%0d: got %b want %b", i, obs_q[i].z, (i == 6));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mid_reset();
        bit ok;
        int cnt = 0;
        tick_mode = 1;
        push_token(1'b0, 6);
        for (int c = 0; c < 50 && cnt < 2; c++) begin
            @(negedge Clock);
            if (w_valid) begin
                cnt++;
                checks++;
                if (w_out !== 1'b0) begin errors++; $display("FAIL mid_bit%0d: got %b want 0", cnt, w_out); end
                if (cnt == 2) Reset = 1'b1;
            end
        end
        @(posedge Clock); #1 Reset = 1'b0;
        model_reset();
        @(negedge Clock);
        checks += 5;
        if (cnt !== 2)         begin errors++; $display("FAIL mid_seen: got %0d want 2", cnt); end
        if (w_out !== 1'b0)    begin errors++; $display("FAIL mid_w_out: got %b want 0", w_out); end
        if (w_valid !== 1'b0)  begin errors++; $display("FAIL mid_w_valid: got %b want 0", w_valid); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        obs_q.delete();
        push_token(1'b1, 4);
        wait_drain(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL mid_drain: timeout, required drain"); end
        if (obs_q.size() !== 4) begin errors++; $display("FAIL mid_count: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks += 2;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_after%0d: got b/z/rd=%b want %b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i].z !== (i == 3)) begin
                errors++;
                $display("FAIL mid_z%0d: got %b want %b", i, obs_q[i].z, (i == 3));
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        do_reset();
        stray = 0;
        tick_mode = 2;
        for (int t = 0; t < 14; t++) begin
            push_token(1'(($urandom)), int'($urandom_range(0, 15)));
        end
        wait_drain(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL rand_drain: timeout, required drain"); end
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        if (stray !== 0) begin errors++; $display("FAIL rand_stray_run_done: got %0d want 0", stray); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_bit%0d: got b/z/rd=%b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_run();
        test_two_tokens();
        test_zero_len();
        test_fill();
        test_pattern();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
